// File: rtl/mem2io_sram_if.sv
// CPU-side memory strobes and SRAM-side bus of the LC-3 memory/IO bridge.
// The master drives the CPU strobes and SRAM read-back; the slave is the bridge.
interface mem2io_sram_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
) ();
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_from_CPU;
  logic [DATA_W-1:0] Data_to_CPU;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic [DATA_W-1:0] SRAM_DQ_in;
  logic [DATA_W-1:0] SRAM_DQ_out;
  logic              SRAM_DQ_oe;

  modport master (
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_from_CPU, SRAM_DQ_in,
    input  Data_to_CPU, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N,
           SRAM_LB_N, SRAM_DQ_out, SRAM_DQ_oe
  );

  modport slave (
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_from_CPU, SRAM_DQ_in,
    output Data_to_CPU, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N,
           SRAM_LB_N, SRAM_DQ_out, SRAM_DQ_oe
  );
endinterface

// File: rtl/mem2io_sram_ctrl.sv
// Bridges LC-3 active-low memory strobes to an async 1Mx16 SRAM; xFFFF maps to
// switches (read) and the hex-display register (write).
module mem2io_sram_ctrl #(
  parameter int unsigned       ADDR_W  = 20,
  parameter int unsigned       DATA_W  = 16,
  parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(20'h0FFFF)
) (
  input  logic                Clk,
  input  logic                Reset,
  mem2io_sram_if.slave        bus,
  input  logic [15:0]         Switches,
  output logic [15:0]         Hex_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_PULSE = 2'd1,
    WR_HOLD  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              io;
  logic              wr_stb;
  logic              rd_stb;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_io;
  logic              oe_n;
  logic              we_n;
  logic              dq_oe;

  assign io     = (bus.ADDR == IO_ADDR);
  assign wr_stb = ~bus.Mem_CE & ~bus.Mem_WE;
  assign rd_stb = ~bus.Mem_CE & ~bus.Mem_OE & bus.Mem_WE;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and SRAM strobes; reset overrides every strobe to inactive.
  always_comb begin
    state_nxt = state;
    oe_n      = 1'b1;
    we_n      = 1'b1;
    dq_oe     = 1'b0;
    case (state)
      IDLE: begin
        oe_n  = ~(rd_stb & ~io);
        dq_oe = wr_stb & ~io;
        if (wr_stb) state_nxt = WR_PULSE;
      end
      WR_PULSE: begin
        we_n      = wr_io;
        dq_oe     = ~wr_io;
        state_nxt = wr_stb ? WR_HOLD : IDLE;
      end
      WR_HOLD: begin
        dq_oe = ~wr_io;
        if (!wr_stb) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (Reset) begin
      oe_n  = 1'b1;
      we_n  = 1'b1;
      dq_oe = 1'b0;
    end
  end

  // Read capture, write latch and hex-display register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_data  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_io    <= 1'b0;
      Hex_data <= '0;
    end else begin
      if (rd_stb) rd_data <= io ? DATA_W'(Switches) : bus.SRAM_DQ_in;
      if (state == IDLE && wr_stb) begin
        wr_addr <= bus.ADDR;
        wr_data <= bus.Data_from_CPU;
        wr_io   <= io;
      end
      if (state == WR_PULSE && wr_io) Hex_data <= 16'(wr_data);
    end
  end

  assign bus.Data_to_CPU = rd_data;
  assign bus.SRAM_CE_N   = bus.Mem_CE;
  assign bus.SRAM_UB_N   = bus.Mem_UB;
  assign bus.SRAM_LB_N   = bus.Mem_LB;
  assign bus.SRAM_OE_N   = oe_n;
  assign bus.SRAM_WE_N   = we_n;
  assign bus.SRAM_DQ_oe  = dq_oe;
  assign bus.SRAM_ADDR   = (state == IDLE) ? bus.ADDR : wr_addr;
  assign bus.SRAM_DQ_out = (state == IDLE) ? bus.Data_from_CPU : wr_data;

endmodule

// File: tb/tb_mem2io_sram_ctrl.sv
// Cycle-table bench for mem2io_sram_ctrl with a read-data scoreboard queue.
module tb_mem2io_sram_ctrl;

  localparam logic [19:0] A_SR = 20'h00123;
  localparam logic [19:0] A_IO = 20'h0FFFF;

  typedef struct {
    logic        rst, ce, oe, we, ub, lb;
    logic [19:0] addr;
    logic [15:0] din, sw, dq;
    logic        e_oe_n, e_we_n, e_dqoe;
    logic [19:0] e_addr;
    logic [15:0] e_dout, e_hex;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Switches = '0;
  logic [15:0] Hex_data;

  mem2io_sram_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  mem2io_sram_ctrl dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus),
    .Switches (Switches),
    .Hex_data (Hex_data)
  );

  always #5 Clk = ~Clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          pulses  = 0;
  int          cur_row = -1;
  vec_t        vecs[$];
  logic [15:0] sb[$];

  always @(negedge Clk) if (bus.SRAM_WE_N === 1'b0) pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h want %h", name, cur_row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, ce, oe, we, ub, lb,
                              input logic [19:0] addr, input logic [15:0] din, sw, dq,
                              input logic e_oe_n, e_we_n, e_dqoe,
                              input logic [19:0] e_addr, input logic [15:0] e_dout, e_hex);
    vec_t v;
    v.rst = rst; v.ce = ce; v.oe = oe; v.we = we; v.ub = ub; v.lb = lb;
    v.addr = addr; v.din = din; v.sw = sw; v.dq = dq;
    v.e_oe_n = e_oe_n; v.e_we_n = e_we_n; v.e_dqoe = e_dqoe;
    v.e_addr = e_addr; v.e_dout = e_dout; v.e_hex = e_hex;
    return v;
  endfunction

  // One cycle: drive after the edge, check at the falling edge, update scoreboard.
  task automatic run_vec(input vec_t v);
    logic [15:0] exp_rd;
    @(posedge Clk); #1;
    Reset             = v.rst;
    bus.Mem_CE        = v.ce;
    bus.Mem_OE        = v.oe;
    bus.Mem_WE        = v.we;
    bus.Mem_UB        = v.ub;
    bus.Mem_LB        = v.lb;
    bus.ADDR          = v.addr;
    bus.Data_from_CPU = v.din;
    bus.SRAM_DQ_in    = v.dq;
    Switches          = v.sw;
    @(negedge Clk);
    chk("sram_oe_n", 32'(bus.SRAM_OE_N), 32'(v.e_oe_n));
    chk("sram_we_n", 32'(bus.SRAM_WE_N), 32'(v.e_we_n));
    chk("sram_dq_oe", 32'(bus.SRAM_DQ_oe), 32'(v.e_dqoe));
    chk("sram_addr", 32'(bus.SRAM_ADDR), 32'(v.e_addr));
    chk("sram_dq_out", 32'(bus.SRAM_DQ_out), 32'(v.e_dout));
    chk("hex_data", 32'(Hex_data), 32'(v.e_hex));
    chk("sram_ce_n", 32'(bus.SRAM_CE_N), 32'(v.ce));
    chk("sram_ub_n", 32'(bus.SRAM_UB_N), 32'(v.ub));
    chk("sram_lb_n", 32'(bus.SRAM_LB_N), 32'(v.lb));
    if (sb.size() > 0) begin
      exp_rd = sb.pop_front();
      chk("data_to_cpu", 32'(bus.Data_to_CPU), 32'(exp_rd));
    end
    if (v.rst) sb.push_back(16'h0000);
    else if (!v.ce && !v.oe && v.we) sb.push_back((v.addr == A_IO) ? v.sw : v.dq);
  endtask

  initial begin
    bus.Mem_CE = 1'b1; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
    bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0;
    bus.ADDR = '0; bus.Data_from_CPU = '0; bus.SRAM_DQ_in = '0;
    repeat (3) @(posedge Clk);

    //                 rst ce oe we ub lb addr      din       sw        dq        oe_n we_n dqoe e_addr    e_dout    e_hex
    // reset with an active write strobe
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, A_SR,     16'h5A5A, 16'h0,    16'h0,    1, 1, 0, A_SR,     16'h5A5A, 16'h0));
    // SRAM write, 3-cycle strobe, then hold-state release cycle
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, A_SR,     16'hBEEF, 16'h0,    16'h0,    1, 1, 1, A_SR,     16'hBEEF, 16'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, A_SR,     16'hBEEF, 16'h0,    16'h0,    1, 0, 1, A_SR,     16'hBEEF, 16'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, A_SR,     16'hBEEF, 16'h0,    16'h0,    1, 1, 1, A_SR,     16'hBEEF, 16'h0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, A_SR,     16'h0,    16'h0,    16'h0,    1, 1, 1, A_SR,     16'hBEEF, 16'h0));
    // SRAM read, 2 cycles
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, A_SR,     16'h0,    16'h0,    16'hBEEF, 0, 1, 0, A_SR,     16'h0,    16'h0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, A_SR,     16'h0,    16'h0,    16'hBEEF, 0, 1, 0, A_SR,     16'h0,    16'h0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 20'h0,    16'h0,    16'h0,    16'h0,    1, 1, 0, 20'h0,    16'h0,    16'h0));
    // I/O write to hex register
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, A_IO,     16'h1A2B, 16'h0,    16'h0,    1, 1, 0, A_IO,     16'h1A2B, 16'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, A_IO,     16'h1A2B, 16'h0,    16'h0,    1, 1, 0, A_IO,     16'h1A2B, 16'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, A_IO,     16'h1A2B, 16'h0,    16'h0,    1, 1, 0, A_IO,     16'h1A2B, 16'h1A2B));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, A_IO,     16'h0,    16'h0,    16'h0,    1, 1, 0, A_IO,     16'h1A2B, 16'h1A2B));
    // I/O read of switches; SRAM bus carries a decoy value
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, A_IO,     16'h0,    16'h00C3, 16'h5555, 1, 1, 0, A_IO,     16'h0,    16'h1A2B));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, A_IO,     16'h0,    16'h00C3, 16'h5555, 1, 1, 0, A_IO,     16'h0,    16'h1A2B));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 20'h0,    16'h0,    16'h0,    16'h0,    1, 1, 0, 20'h0,    16'h0,    16'h1A2B));
    // OE and WE both low: treated as a write, OE_N never asserted
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 20'h00456, 16'h7777, 16'h0,   16'h0,    1, 1, 1, 20'h00456, 16'h7777, 16'h1A2B));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 20'h00456, 16'h7777, 16'h0,   16'h0,    1, 0, 1, 20'h00456, 16'h7777, 16'h1A2B));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 20'h00456, 16'h7777, 16'h0,   16'h0,    1, 1, 1, 20'h00456, 16'h7777, 16'h1A2B));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 20'h0,    16'h0,    16'h0,    16'h0,    1, 1, 1, 20'h00456, 16'h7777, 16'h1A2B));
    // CE high: no strobes, FSM stays idle
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 20'h00789, 16'h1111, 16'h0,   16'h0,    1, 1, 0, 20'h00789, 16'h1111, 16'h1A2B));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 20'h0078A, 16'h1112, 16'h0,   16'h0,    1, 1, 0, 20'h0078A, 16'h1112, 16'h1A2B));
    // reset during W1
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 20'h00100, 16'hAAAA, 16'h0,   16'h0,    1, 1, 0, 20'h00100, 16'hAAAA, 16'h1A2B));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 20'h0,    16'h0,    16'h0,    16'h0,    1, 1, 0, 20'h0,    16'h0,    16'h0));
    // long write strobe; bus inputs change after W2 and must not leak through
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 20'h00200, 16'h1234, 16'h0,   16'h0,    1, 1, 1, 20'h00200, 16'h1234, 16'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 20'h00200, 16'h1234, 16'h0,   16'h0,    1, 0, 1, 20'h00200, 16'h1234, 16'h0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 20'h00201, 16'hFFFF, 16'h0, 16'h0,    1, 1, 1, 20'h00200, 16'h1234, 16'h0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 20'h00201, 16'hFFFF, 16'h0,   16'h0,    1, 1, 1, 20'h00200, 16'h1234, 16'h0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 20'h0,    16'h0,    16'h0,    16'h0,    1, 1, 0, 20'h0,    16'h0,    16'h0));
    // one-cycle strobe: pulse still issued, then abort to idle
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 20'h00300, 16'h4321, 16'h0,   16'h0,    1, 1, 1, 20'h00300, 16'h4321, 16'h0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 20'h0,    16'h0,    16'h0,    16'h0,    1, 0, 1, 20'h00300, 16'h4321, 16'h0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 20'h0,    16'h0,    16'h0,    16'h0,    1, 1, 0, 20'h0,    16'h0,    16'h0));
    // 3-cycle read re-captures every cycle
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 20'h00400, 16'h0,   16'h0,    16'h0001, 0, 1, 0, 20'h00400, 16'h0,    16'h0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 20'h00400, 16'h0,   16'h0,    16'h0002, 0, 1, 0, 20'h00400, 16'h0,    16'h0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 20'h00400, 16'h0,   16'h0,    16'h0003, 0, 1, 0, 20'h00400, 16'h0,    16'h0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 20'h0,    16'h0,    16'h0,    16'h0,    1, 1, 0, 20'h0,    16'h0,    16'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      cur_row = i;
      run_vec(vecs[i]);
    end

    // Whole-run checks: one WE pulse per SRAM write strobe, scoreboard drained.
    cur_row = -1;
    chk("we_pulse_count", 32'(pulses), 32'd4);
    chk("scoreboard_left", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem2io_sram_ctrl.md
# mem2io_sram_ctrl

Memory/IO bridge between the LC-3 control unit's active-low memory strobes and the 1M×16 asynchronous SRAM. It also maps the LC-3 I/O address xFFFF to the board switches (reads) and a hex-display register (writes). The block converts the control unit's fixed-length strobes into SRAM cycles with the following properties:

- a registered read capture;
- a setup/pulse/hold write sequence with bus turnaround;
- exactly one SRAM write per write strobe.

## Interface
- ADDR_W, 20, CPU/SRAM word-address width
- DATA_W, 16, data width
- IO_ADDR, 20'h0FFFF, memory-mapped switch/hex address
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  reset; one clock; synchronous, active-high
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  in  1 each  active-low strobes from the control unit
- ADDR  in  ADDR_W  word address (from MAR, zero-extended)
- Data_from_CPU  in  DATA_W  write data (MDR)
- Data_to_CPU  out  DATA_W  read data to MDR input mux
- Switches  in  16  board switches
- Hex_data  out  16  hex-display register, one nibble per digit
- SRAM_ADDR  out  ADDR_W  SRAM address
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes
- SRAM_DQ_in  in  DATA_W  SRAM data read back
- SRAM_DQ_out  out  DATA_W  data driven onto SRAM bus
- SRAM_DQ_oe  out  1  tristate enable for SRAM_DQ_out

## Operation

**Decode and pass-through**
- io = (ADDR == IO_ADDR).
- Write strobe active when ~Mem_CE & ~Mem_WE. Read strobe active when ~Mem_CE & ~Mem_OE & Mem_WE. If both OE and WE are low, the access is a write.
- SRAM_CE_N = Mem_CE.
- SRAM_UB_N = Mem_UB; SRAM_LB_N = Mem_LB.

**Read path (combinational strobe, registered data)**
- SRAM_OE_N = 0 iff read strobe active, ~io, FSM in IDLE, and ~Reset.
- Every cycle with the read strobe active: rd_data <= io ? Switches : SRAM_DQ_in.
- Data_to_CPU = rd_data at all times.

**Write FSM states**
- IDLE:
  - On write strobe: latch wr_addr <= ADDR, wr_data <= Data_from_CPU, wr_io <= io; go to WR_PULSE.
  - Otherwise stay in IDLE.
- WR_PULSE:
  - SRAM_WE_N = ~wr_io (low for SRAM writes only).
  - If wr_io: Hex_data <= wr_data.
  - If Mem_WE & Mem_CE are still low, go to WR_HOLD; else go to IDLE (abort; the pulse already issued stands).
- WR_HOLD:
  - SRAM_WE_N = 1.
  - Stay while the write strobe is active; go to IDLE when it releases.
  - No further write pulse is issued while in WR_HOLD.

**Write-path outputs**
- SRAM_WE_N is 1 in every state other than WR_PULSE.
- SRAM_ADDR = ADDR in IDLE, wr_addr otherwise.
- SRAM_DQ_out = Data_from_CPU in IDLE, wr_data otherwise.
- SRAM_DQ_oe:
  - 1 in WR_PULSE and WR_HOLD when ~wr_io.
  - 1 in IDLE when the write strobe is active and ~io.
  - 0 otherwise; never 1 while SRAM_OE_N = 0.

**Reset**
- Reset value of every register is 0: rd_data, wr_addr, wr_data, wr_io, Hex_data.
- FSM resets to IDLE.
- While Reset is high: SRAM_OE_N = SRAM_WE_N = 1 and SRAM_DQ_oe = 0, regardless of strobes.
- Reset mid-write returns the FSM to IDLE at the next edge. No write pulse is issued in the reset cycle.
- Data_to_CPU = 0 after reset.

## Timing
- **Read:** the control unit holds Mem_OE low for 2 cycles (R1, R2) and loads MDR in R2.
  - SRAM_OE_N is low in R1 and R2.
  - rd_data captures at the end of R1, so Data_to_CPU is valid throughout R2.
  - Latency is 1 cycle from first strobe cycle to valid data. Reads longer than 2 cycles re-capture every cycle.
- **Write:** the control unit holds Mem_WE low for 3 cycles (W1–W3).
  - W1 = IDLE: address and data driven, WE_N high (setup).
  - W2 = WR_PULSE: WE_N low.
  - W3 = WR_HOLD: WE_N high, data still driven (hold).
  - The FSM returns to IDLE on the first edge with Mem_WE high.
- **Back-to-back write strobes:** a new write requires at least one cycle in IDLE between them.
- **Hex_data:** updates on the edge ending W2.

## Test plan
- **SRAM write:** reset, then write strobe 3 cycles with ADDR=20'h00123, data=16'hBEEF → SRAM_WE_N low exactly in cycle 2; SRAM_DQ_oe=1 in cycles 1–3; SRAM_ADDR=20'h00123 throughout; exactly one WE pulse.
- **SRAM read:** read strobe 2 cycles at 20'h00123, SRAM model returns 16'hBEEF → SRAM_OE_N low both cycles; SRAM_DQ_oe=0; Data_to_CPU=16'hBEEF in cycle 2.
- **I/O write and read:**
  - Write 16'h1A2B to 20'h0FFFF → SRAM_WE_N stays 1; SRAM_DQ_oe=0; Hex_data=16'h1A2B after cycle 2.
  - Read 20'h0FFFF with Switches=16'h00C3 → SRAM_OE_N stays 1; Data_to_CPU=16'h00C3 in cycle 2.
- **Simultaneous strobes and CE:**
  - Mem_OE and Mem_WE both low → write sequence; SRAM_OE_N=1 throughout.
  - Mem_CE high → no SRAM strobe asserted; FSM stays in IDLE.
- **Reset mid-write:** assert Reset during W1 → no WE pulse; FSM in IDLE; Hex_data=0; SRAM_DQ_oe=0 while Reset is high.
- **Long strobe:** Mem_WE held low 6 cycles → single WE pulse in cycle 2; FSM in WR_HOLD until release, then IDLE next edge.
